l5q1c_adder: RTL and testbench



---
 rtl/l5q1c_adder.sv | 46 ++++
 tb/tb_l5q1c_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/l5q1c_adder.sv
// Registered WIDTH-bit ripple-carry adder: {c_out, s} = a + b + c_in, one cycle latency.
// Both outputs come straight from flops and clear asynchronously while rst_n is low.
module l5q1c_adder #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             c_out,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             c_out_d;

  // Ripple chain: carry[i] enters bit i, carry[WIDTH] is the carry-out.
  always_comb begin
    carry    = '0;
    sum_d    = '0;
    carry[0] = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    c_out_d = carry[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      s_q     <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign s     = s_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_l5q1c_adder.sv
// Self-checking bench for l5q1c_adder: directed, reset and random operands against
// an arithmetic reference with a one-cycle expectation queue.
module tb_l5q1c_adder;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_out;
  logic [WIDTH-1:0] s;

  int total;
  int bad;
  int exp_q[$];

  l5q1c_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .c_in  (c_in),
    .a     (a),
    .b     (b),
    .c_out (c_out),
    .s     (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: obs=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int observed();
    return int'({c_out, s});
  endfunction

  // Drive operands and queue the full-width arithmetic result expected after the next edge.
  task automatic drive(input int x, input int y, input int z);
    a    = x[WIDTH-1:0];
    b    = y[WIDTH-1:0];
    c_in = z[0];
    exp_q.push_back(x + y + z);
  endtask

  task automatic step_check(input string tag);
    int e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, observed(), -1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, observed(), e);
    end
  endtask

  initial begin
    int da[6];
    int db[6];
    int dc[6];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = 5'd5;
    b     = 5'd7;
    c_in  = 1'b1;

    #1;
    chk("rst_initial", observed(), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", observed(), 0);
    end

    rst_n = 1'b1;
    exp_q.push_back(5 + 7 + 1);
    step_check("rst_release");

    da = '{1, 16, 31, 0, 31, 15};
    db = '{1, 16, 31, 0, 0, 16};
    dc = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      drive(da[i], db[i], dc[i]);
      step_check($sformatf("directed%0d", i));
    end

    drive(3, 4, 0);
    step_check("pre_mid_rst");
    drive(9, 10, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", observed(), 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_no_stale", observed(), 0);
    step_check("mid_rst_first");

    for (int i = 0; i < 30; i++) begin
      drive(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
      step_check($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
